// File: rtl/sip_edge_scheduler.sv
// rtl/sip_edge_scheduler.sv - sequences the siphash core to produce cuckatoo (u,v) edge endpoints
// Optional poll timeout guarded by SIP_SCHED_TIMEOUT_EN.
module sip_edge_scheduler #(
   parameter int EDGE_BITS     = 8,
   parameter int TIMEOUT_POLLS = 64
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [63:0]          key0_i,
   input  logic [63:0]          key1_i,
   input  logic [63:0]          key2_i,
   input  logic [63:0]          key3_i,
   input  logic [EDGE_BITS:0]   num_edges_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 sip_cs_o,
   output logic                 sip_we_o,
   output logic [7:0]           sip_addr_o,
   output logic [63:0]          sip_wdata_o,
   input  logic [63:0]          sip_rdata_i,
   output logic                 edge_valid_o,
   input  logic                 edge_ready_i,
   output logic [EDGE_BITS-1:0] edge_idx_o,
   output logic [EDGE_BITS-1:0] edge_u_o,
   output logic [EDGE_BITS-1:0] edge_v_o
);

   // Access states WK0..RD are ordered so each one's successor is the next encoding.
   typedef enum logic [3:0] {
      S_IDLE, S_WK0, S_WK1, S_WK2, S_WK3, S_INIT, S_WNONCE,
      S_COMP, S_FINAL, S_RD, S_EMIT, S_FIN
   } state_t;

   state_t               state_q, state_d;
   logic [3:0][63:0]     key_q, key_d;
   logic [EDGE_BITS:0]   num_q, num_d, edge_q, edge_d, edge_nx;
   logic                 side_q, side_d, phase_q, phase_d, poll_q, poll_d;
   logic [EDGE_BITS-1:0] u_q, u_d, v_q, v_d;
   logic                 in_access;
   logic                 unused_ok;

`ifdef SIP_SCHED_TIMEOUT_EN
   localparam int PCW = $clog2(TIMEOUT_POLLS + 1);
   logic [PCW-1:0] pcnt_q, pcnt_d;
   logic           err_q, err_d;
   assign err_o     = err_q;
   assign unused_ok = ^sip_rdata_i[63:EDGE_BITS];
`else
   assign err_o     = 1'b0;
   assign unused_ok = ^{sip_rdata_i[63:EDGE_BITS], TIMEOUT_POLLS};
`endif

   assign edge_nx = edge_q + 1'b1;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         key_q   <= '0;
         num_q   <= '0;
         edge_q  <= '0;
         side_q  <= 1'b0;
         phase_q <= 1'b0;
         poll_q  <= 1'b0;
         u_q     <= '0;
         v_q     <= '0;
`ifdef SIP_SCHED_TIMEOUT_EN
         pcnt_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         num_q   <= num_d;
         edge_q  <= edge_d;
         side_q  <= side_d;
         phase_q <= phase_d;
         poll_q  <= poll_d;
         u_q     <= u_d;
         v_q     <= v_d;
`ifdef SIP_SCHED_TIMEOUT_EN
         pcnt_q  <= pcnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      num_d   = num_q;
      edge_d  = edge_q;
      side_d  = side_q;
      phase_d = phase_q;
      poll_d  = poll_q;
      u_d     = u_q;
      v_d     = v_q;
`ifdef SIP_SCHED_TIMEOUT_EN
      pcnt_d  = pcnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               key_d   = {key3_i, key2_i, key1_i, key0_i};
               num_d   = num_edges_i;
               edge_d  = '0;
               side_d  = 1'b0;
               phase_d = 1'b0;
               poll_d  = 1'b0;
               u_d     = '0;
               v_d     = '0;
`ifdef SIP_SCHED_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = (num_edges_i == '0) ? S_FIN : S_WK0;
            end
         end
         S_WK0, S_WK1, S_WK2, S_WK3, S_WNONCE: begin
            phase_d = ~phase_q;
            if (phase_q) state_d = state_t'(state_q + 4'd1);
         end
         // Command write, then STATUS polls until the core reports ready.
         S_INIT, S_COMP, S_FINAL: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (!poll_q) begin
                  poll_d = 1'b1;
`ifdef SIP_SCHED_TIMEOUT_EN
                  pcnt_d = '0;
`endif
               end else if (sip_rdata_i[0]) begin
                  poll_d  = 1'b0;
                  state_d = state_t'(state_q + 4'd1);
               end
`ifdef SIP_SCHED_TIMEOUT_EN
               else if (pcnt_q == PCW'(TIMEOUT_POLLS - 1)) begin
                  poll_d  = 1'b0;
                  err_d   = 1'b1;
                  state_d = S_FIN;
               end else begin
                  pcnt_d = pcnt_q + 1'b1;
               end
`endif
            end
         end
         S_RD: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (!side_q) begin
                  u_d     = sip_rdata_i[EDGE_BITS-1:0];
                  side_d  = 1'b1;
                  state_d = S_INIT;
               end else begin
                  v_d     = sip_rdata_i[EDGE_BITS-1:0];
                  state_d = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            if (edge_ready_i) begin
               edge_d  = edge_nx;
               side_d  = 1'b0;
               state_d = (edge_nx == num_q) ? S_FIN : S_INIT;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bus outputs decode straight from state so reset drops cs without waiting for a clock.
   assign in_access = (state_q >= S_WK0) && (state_q <= S_RD);
   assign sip_cs_o  = in_access && !phase_q;
   assign sip_we_o  = sip_cs_o && !poll_q && (state_q != S_RD);

   always_comb begin
      sip_addr_o  = 8'h00;
      sip_wdata_o = 64'd0;
      if (sip_cs_o) begin
         case (state_q)
            S_WK0:    begin sip_addr_o = 8'h10; sip_wdata_o = key_q[0]; end
            S_WK1:    begin sip_addr_o = 8'h11; sip_wdata_o = key_q[1]; end
            S_WK2:    begin sip_addr_o = 8'h12; sip_wdata_o = key_q[2]; end
            S_WK3:    begin sip_addr_o = 8'h13; sip_wdata_o = key_q[3]; end
            S_INIT:   begin sip_addr_o = poll_q ? 8'h09 : 8'h08; sip_wdata_o = poll_q ? 64'd0 : 64'd1; end
            S_COMP:   begin sip_addr_o = poll_q ? 8'h09 : 8'h08; sip_wdata_o = poll_q ? 64'd0 : 64'd2; end
            S_FINAL:  begin sip_addr_o = poll_q ? 8'h09 : 8'h08; sip_wdata_o = poll_q ? 64'd0 : 64'd4; end
            S_WNONCE: begin sip_addr_o = 8'h18; sip_wdata_o = 64'({edge_q, side_q}); end
            S_RD:     sip_addr_o = 8'h20;
            default:  sip_addr_o = 8'h00;
         endcase
      end
   end

   assign busy_o       = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done_o       = (state_q == S_FIN);
   assign edge_valid_o = (state_q == S_EMIT);
   assign edge_idx_o   = edge_q[EDGE_BITS-1:0];
   assign edge_u_o     = u_q;
   assign edge_v_o     = v_q;

endmodule

// File: tb/tb_sip_edge_scheduler.sv
// tb/tb_sip_edge_scheduler.sv - self-checking bench for sip_edge_scheduler with a siphash stub
// Define SIP_SCHED_TIMEOUT_EN to build and check the poll timeout variant.
module tb_sip_edge_scheduler;
   localparam int EB = 8;
`ifdef SIP_SCHED_TIMEOUT_EN
   localparam int TP = 3;
`else
   localparam int TP = 64;
`endif

   logic          clk = 0, rst = 1, start = 0, edge_ready = 1;
   logic [63:0]   k0 = 0, k1 = 0, k2 = 0, k3 = 0, sip_rdata = 0;
   logic [EB:0]   num = 0;
   logic          busy, done, err, sip_cs, sip_we, edge_valid;
   logic [7:0]    sip_addr;
   logic [63:0]   sip_wdata;
   logic [EB-1:0] edge_idx, edge_u, edge_v;

   int compared = 0, failed = 0, cyc = 0, t_start = 0;
   int cs_total = 0, consec_cs = 0, status_reads = 0, comp_seen = 0, bad_we = 0, overlap = 0;
   int done_total = 0, done_cyc = 0, stub_polls = 0, stall_polls = 0;
   bit prev_cs = 0;
   logic [63:0] stub_nonce = 0;
   logic [7:0]    keyw_addr[$];
   logic [63:0]   keyw_data[$];
   logic [EB-1:0] got_idx[$], got_u[$], got_v[$];
   int b_edge, b_cs, b_st, b_done, b_cc, b_bw, b_ov, b_key;

   sip_edge_scheduler #(.EDGE_BITS(EB), .TIMEOUT_POLLS(TP)) dut (
      .clock_i(clk), .reset_i(rst), .start_i(start),
      .key0_i(k0), .key1_i(k1), .key2_i(k2), .key3_i(k3), .num_edges_i(num),
      .busy_o(busy), .done_o(done), .err_o(err),
      .sip_cs_o(sip_cs), .sip_we_o(sip_we), .sip_addr_o(sip_addr),
      .sip_wdata_o(sip_wdata), .sip_rdata_i(sip_rdata),
      .edge_valid_o(edge_valid), .edge_ready_i(edge_ready),
      .edge_idx_o(edge_idx), .edge_u_o(edge_u), .edge_v_o(edge_v));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Siphash stub and bus/stream monitor, evaluated mid-cycle.
   always @(negedge clk) begin
      if (sip_cs) begin
         cs_total++;
         if (prev_cs) consec_cs++;
         if (sip_we) begin
            if (sip_addr >= 8'h10 && sip_addr <= 8'h13) begin
               keyw_addr.push_back(sip_addr);
               keyw_data.push_back(sip_wdata);
            end
            if (sip_addr == 8'h18) stub_nonce = sip_wdata;
            if (sip_addr == 8'h08) begin
               stub_polls = 0;
               if (sip_wdata == 64'd2) comp_seen++;
            end
         end else if (sip_addr == 8'h09) begin
            status_reads++;
            sip_rdata = (stub_polls >= stall_polls) ? 64'd1 : 64'd0;
            stub_polls++;
         end else if (sip_addr == 8'h20) begin
            sip_rdata = 64'hDEAD_0000_0000_0000 | stub_nonce;
         end
      end
      if (sip_we && !sip_cs) bad_we++;
      if (edge_valid && sip_cs) overlap++;
      prev_cs = sip_cs;
      if (edge_valid && edge_ready) begin
         got_idx.push_back(edge_idx);
         got_u.push_back(edge_u);
         got_v.push_back(edge_v);
      end
      if (done) begin
         done_total++;
         done_cyc = cyc;
      end
   end

   task automatic snap();
      b_edge = got_idx.size(); b_cs = cs_total; b_st = status_reads; b_done = done_total;
      b_cc = consec_cs; b_bw = bad_we; b_ov = overlap; b_key = keyw_addr.size();
   endtask

   task automatic start_job(input int n, input bit hold);
      @(posedge clk); #1;
      num = (EB+1)'(n);
      start = 1;
      t_start = cyc;
      if (!hold) begin
         @(posedge clk); #1;
         start = 0;
      end
   endtask

   task automatic wait_done(input int budget, input bit rnd, input string nm);
      int  base;
      bit  got;
      base = done_total;
      got  = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(posedge clk); #1;
         if (done_total != base) got = 1;
         else if (rnd) edge_ready = 1'($urandom_range(0, 1));
      end
      start = 0;
      compared++;
      if (!got) begin
         failed++;
         $display("FAIL %s_done_wait: no done within %0d cycles", nm, budget);
      end
   endtask

   // Reference: edge e yields (e, 2e & mask, (2e+1) & mask); each wait costs (1+stall) status reads.
   task automatic check_job(input string nm, input int n, input int stall, input int extra);
      int exp_cs, exp_st, exp_lat;
      logic [EB-1:0] ei, eu, ev;
      exp_cs  = (n == 0) ? 0 : 4 + n * 2 * (8 + 3 * stall);
      exp_st  = n * 6 * (1 + stall);
      exp_lat = (n == 0) ? 1 : 8 + n * (2 * (16 + 6 * stall) + 1) + 1 + extra;
      compared++;
      if (got_idx.size() - b_edge !== n) begin
         failed++;
         $display("FAIL %s_edge_count: got %0d expected %0d", nm, got_idx.size() - b_edge, n);
      end else begin
         for (int e = 0; e < n; e++) begin
            ei = EB'(e); eu = EB'(2 * e); ev = EB'(2 * e + 1);
            compared++;
            if (got_idx[b_edge+e] !== ei || got_u[b_edge+e] !== eu || got_v[b_edge+e] !== ev) begin
               failed++;
               $display("FAIL %s_edge%0d: got (%0d,%h,%h) expected (%0d,%h,%h)", nm, e,
                        got_idx[b_edge+e], got_u[b_edge+e], got_v[b_edge+e], ei, eu, ev);
               break;
            end
         end
      end
      compared++;
      if (cs_total - b_cs !== exp_cs) begin
         failed++;
         $display("FAIL %s_cs_cycles: got %0d expected %0d", nm, cs_total - b_cs, exp_cs);
      end
      compared++;
      if (status_reads - b_st !== exp_st) begin
         failed++;
         $display("FAIL %s_status_reads: got %0d expected %0d", nm, status_reads - b_st, exp_st);
      end
      compared++;
      if (done_total - b_done !== 1) begin
         failed++;
         $display("FAIL %s_done_pulses: got %0d expected 1", nm, done_total - b_done);
      end
      compared++;
      if ((consec_cs - b_cc) + (bad_we - b_bw) + (overlap - b_ov) !== 0) begin
         failed++;
         $display("FAIL %s_bus_protocol: consec_cs %0d stray_we %0d cs_during_emit %0d expected 0 0 0",
                  nm, consec_cs - b_cc, bad_we - b_bw, overlap - b_ov);
      end
      if (extra >= 0) begin
         compared++;
         if (done_cyc - t_start !== exp_lat) begin
            failed++;
            $display("FAIL %s_latency: got %0d expected %0d", nm, done_cyc - t_start, exp_lat);
         end
      end
      compared++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         failed++;
         $display("FAIL %s_end_flags: busy %b err %b expected 0 0", nm, busy, err);
      end
   endtask

   task automatic test_reset();
      #1;
      compared++;
      if ({busy, done, err, sip_cs, sip_we, edge_valid} !== 6'b0 || sip_addr !== 8'h00 ||
          sip_wdata !== 64'd0 || edge_idx !== '0 || edge_u !== '0 || edge_v !== '0) begin
         failed++;
         $display("FAIL reset_outputs: got busy%b done%b err%b cs%b we%b valid%b addr %h idx %h expected all 0",
                  busy, done, err, sip_cs, sip_we, edge_valid, sip_addr, edge_idx);
      end
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic test_basic();
      stall_polls = 0; edge_ready = 1;
      k0 = 1; k1 = 2; k2 = 3; k3 = 4;
      snap();
      start_job(3, 0);
      wait_done(400, 0, "basic");
      check_job("basic", 3, 0, 0);
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (keyw_addr[b_key+i] !== 8'(8'h10 + i) || keyw_data[b_key+i] !== 64'(i + 1)) begin
            failed++;
            $display("FAIL key_write%0d: got addr %h data %0d expected addr %h data %0d",
                     i, keyw_addr[b_key+i], keyw_data[b_key+i], 8'h10 + i, i + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      int  n_cs;
      bit  seen;
      stall_polls = 0; edge_ready = 0;
      snap();
      start_job(3, 0);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (edge_valid) seen = 1; else begin @(posedge clk); #1; end
      end
      edge_ready = 1;
      @(posedge clk); #1;
      edge_ready = 0;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (edge_valid && edge_idx == 8'd1) seen = 1; else begin @(posedge clk); #1; end
      end
      compared++;
      if (!seen) begin
         failed++;
         $display("FAIL bp_edge1_wait: edge 1 never offered");
      end
      n_cs = cs_total;
      for (int k = 0; k < 10; k++) begin
         compared++;
         if (edge_valid !== 1'b1 || edge_idx !== 8'd1 || edge_u !== 8'h02 || edge_v !== 8'h03) begin
            failed++;
            $display("FAIL bp_hold%0d: got v%b (%0d,%h,%h) expected v1 (1,02,03)",
                     k, edge_valid, edge_idx, edge_u, edge_v);
         end
         @(posedge clk); #1;
      end
      compared++;
      if (cs_total !== n_cs) begin
         failed++;
         $display("FAIL bp_no_access: got %0d cs cycles expected 0", cs_total - n_cs);
      end
      edge_ready = 1;
      wait_done(400, 0, "bp");
      check_job("bp", 3, 0, 10);
   endtask

`ifdef SIP_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      stall_polls = 5; edge_ready = 1;
      snap();
      start_job(3, 0);
      wait_done(400, 0, "timeout");
      compared++;
      if (err !== 1'b1 || got_idx.size() !== b_edge || done_total - b_done !== 1) begin
         failed++;
         $display("FAIL timeout_abort: err %b edges %0d done %0d expected 1 0 1",
                  err, got_idx.size() - b_edge, done_total - b_done);
      end
      compared++;
      if (status_reads - b_st !== TP || cs_total - b_cs !== 5 + TP) begin
         failed++;
         $display("FAIL timeout_accesses: status %0d cs %0d expected %0d %0d",
                  status_reads - b_st, cs_total - b_cs, TP, 5 + TP);
      end
      stall_polls = 0;
      snap();
      start_job(1, 0);
      wait_done(200, 0, "timeout_clear");
      check_job("timeout_clear", 1, 0, 0);
   endtask
`else
   task automatic test_stall_polls();
      stall_polls = 5; edge_ready = 1;
      snap();
      start_job(2, 0);
      wait_done(1000, 0, "stall");
      check_job("stall", 2, 5, 0);
      stall_polls = 0;
   endtask
`endif

   task automatic test_zero_edges();
      stall_polls = 0; edge_ready = 1;
      snap();
      start_job(0, 0);
      wait_done(20, 0, "zero");
      check_job("zero", 0, 0, 0);
   endtask

   task automatic test_full_range();
      stall_polls = 0; edge_ready = 1;
      snap();
      start_job(1 << EB, 0);
      wait_done(10000, 0, "full");
      check_job("full", 1 << EB, 0, 0);
   endtask

   task automatic test_random();
      int n, s;
      for (int it = 0; it < 4; it++) begin
         n = $urandom_range(1, 5);
         s = $urandom_range(0, 2);
         stall_polls = s;
         k0 = {$urandom, $urandom}; k1 = {$urandom, $urandom};
         k2 = {$urandom, $urandom}; k3 = {$urandom, $urandom};
         snap();
         start_job(n, 1);
         wait_done(3000, 1, "random");
         check_job("random", n, s, -1);
      end
      edge_ready = 1;
      stall_polls = 0;
   endtask

   task automatic test_reset_mid_comp();
      bit seen;
      stall_polls = 0; edge_ready = 1;
      start_job(2, 0);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk); #1;
         if (sip_cs && sip_we && sip_addr == 8'h08 && sip_wdata == 64'd2) seen = 1;
      end
      compared++;
      if (!seen || busy !== 1'b1) begin
         failed++;
         $display("FAIL midcomp_reach: seen %0d busy %b expected 1 1", seen, busy);
      end
      #2 rst = 1;
      #1;
      compared++;
      if (busy !== 1'b0 || sip_cs !== 1'b0 || edge_valid !== 1'b0 || sip_we !== 1'b0) begin
         failed++;
         $display("FAIL midcomp_async_reset: busy %b cs %b valid %b we %b expected 0 0 0 0",
                  busy, sip_cs, edge_valid, sip_we);
      end
      @(posedge clk); #1;
      rst = 0;
      snap();
      start_job(2, 0);
      wait_done(300, 0, "after_reset");
      check_job("after_reset", 2, 0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
`ifdef SIP_SCHED_TIMEOUT_EN
      test_timeout();
`else
      test_stall_polls();
`endif
      test_zero_edges();
      test_random();
      test_full_range();
      test_reset_mid_comp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
